// File: rtl/ps2_pkg.sv
// Shared constants, keymap entry type and frame FSM states for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] CODE_E0 = 8'hE0;
    localparam logic [7:0] CODE_F0 = 8'hF0;
    localparam logic [7:0] CODE_E1 = 8'hE1;

    localparam logic [7:0] CODE_BAT_OK   = 8'hAA;
    localparam logic [7:0] CODE_BAT_FAIL = 8'hFC;
    localparam logic [7:0] CODE_OVR_00   = 8'h00;
    localparam logic [7:0] CODE_OVR_FF   = 8'hFF;

    // Bytes following E1 in the Pause make sequence.
    localparam int PAUSE_SKIP = 7;

    typedef struct packed {
        logic       hit;
        logic       is_mod;
        logic [7:0] idx;
    } key_entry_t;

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} frame_state_t;

    function automatic key_entry_t key_mat(input logic [7:0] idx);
        return '{hit: 1'b1, is_mod: 1'b0, idx: idx};
    endfunction

    function automatic key_entry_t key_mod(input logic [7:0] idx);
        return '{hit: 1'b1, is_mod: 1'b1, idx: idx};
    endfunction

    function automatic logic is_reset_code(input logic [7:0] code);
        return (code == CODE_BAT_OK) || (code == CODE_BAT_FAIL) ||
               (code == CODE_OVR_00) || (code == CODE_OVR_FF);
    endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Micro-80 8x7 keymap: {ext, scan code} -> matrix bit (row*7+col) or modifier line.
module ps2_keymap
    import ps2_pkg::*;
(
    input  logic [8:0] key,
    output key_entry_t entry
);

    always_comb begin
        case (key)
            9'h045: entry = key_mat(8'd0);   // 0
            9'h016: entry = key_mat(8'd1);   // 1
            9'h01E: entry = key_mat(8'd2);   // 2
            9'h026: entry = key_mat(8'd3);   // 3
            9'h025: entry = key_mat(8'd4);   // 4
            9'h02E: entry = key_mat(8'd5);   // 5
            9'h036: entry = key_mat(8'd6);   // 6
            9'h03D, 9'h06C: entry = key_mat(8'd7);   // 7, keypad 7
            9'h03E, 9'h075: entry = key_mat(8'd8);   // 8, keypad 8
            9'h046, 9'h07D: entry = key_mat(8'd9);   // 9, keypad 9
            9'h01C: entry = key_mat(8'd10);  // A
            9'h032: entry = key_mat(8'd11);  // B
            9'h021: entry = key_mat(8'd12);  // C
            9'h023: entry = key_mat(8'd13);  // D
            9'h024: entry = key_mat(8'd14);  // E
            9'h02B: entry = key_mat(8'd15);  // F
            9'h034: entry = key_mat(8'd16);  // G
            9'h033: entry = key_mat(8'd17);  // H
            9'h043: entry = key_mat(8'd18);  // I
            9'h03B: entry = key_mat(8'd19);  // J
            9'h042: entry = key_mat(8'd20);  // K
            9'h04B: entry = key_mat(8'd21);  // L
            9'h03A: entry = key_mat(8'd22);  // M
            9'h031: entry = key_mat(8'd23);  // N
            9'h044: entry = key_mat(8'd24);  // O
            9'h04D: entry = key_mat(8'd25);  // P
            9'h015: entry = key_mat(8'd26);  // Q
            9'h02D: entry = key_mat(8'd27);  // R
            9'h01B: entry = key_mat(8'd28);  // S
            9'h02C: entry = key_mat(8'd29);  // T
            9'h03C: entry = key_mat(8'd30);  // U
            9'h02A: entry = key_mat(8'd31);  // V
            9'h01D: entry = key_mat(8'd32);  // W
            9'h022: entry = key_mat(8'd33);  // X
            9'h035: entry = key_mat(8'd34);  // Y
            9'h01A: entry = key_mat(8'd35);  // Z
            9'h029: entry = key_mat(8'd36);  // Space
            9'h05A: entry = key_mat(8'd37);  // Enter
            9'h070: entry = key_mat(8'd38);  // keypad 0
            9'h069: entry = key_mat(8'd39);  // keypad 1
            9'h072: entry = key_mat(8'd40);  // keypad 2
            9'h07A: entry = key_mat(8'd41);  // keypad 3
            9'h06B: entry = key_mat(8'd42);  // keypad 4
            9'h073: entry = key_mat(8'd43);  // keypad 5
            9'h074: entry = key_mat(8'd44);  // keypad 6
            9'h00D: entry = key_mat(8'd45);  // Tab
            9'h076: entry = key_mat(8'd46);  // Esc
            9'h04E: entry = key_mat(8'd47);  // Minus
            9'h049: entry = key_mat(8'd48);  // Period
            9'h16B: entry = key_mat(8'd49);  // Left
            9'h174: entry = key_mat(8'd50);  // Right
            9'h175: entry = key_mat(8'd51);  // Up
            9'h172: entry = key_mat(8'd52);  // Down
            9'h16C: entry = key_mat(8'd53);  // Home
            9'h15A: entry = key_mat(8'd54);  // keypad Enter
            9'h012, 9'h059: entry = key_mat(8'd55);  // Shift (both)
            9'h066: entry = key_mod(8'd0);   // Backspace -> RUS
            9'h007: entry = key_mod(8'd1);   // F12 -> US
            9'h014, 9'h114: entry = key_mod(8'd2);   // Ctrl -> SS
            default: entry = '0;
        endcase
    end

endmodule

// File: rtl/ps2_key_matrix.sv
// PS/2 receiver with prefix decoding and an active-low key matrix scanned by the
// emulated machine's PPI.
module ps2_key_matrix
    import ps2_pkg::*;
#(
    parameter int SAMPLE_DIV    = 250,
    parameter int TIMEOUT_TICKS = 4000,
    parameter int ROWS          = 8,
    parameter int COLS          = 7,
    parameter int MODS          = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ps2_clk,
    input  logic            ps2_dat,
    input  logic [ROWS-1:0] row_sel,
    output logic [COLS-1:0] col_out,
    output logic [MODS-1:0] mod_out,
    output logic            code_valid,
    output logic [7:0]      code_byte,
    output logic            frame_err
);

    localparam int NKEYS = ROWS * COLS;
    localparam int DIV_W = $clog2(SAMPLE_DIV + 1);
    localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

    logic [1:0]       clk_sync, dat_sync;
    logic             clk_prev;
    logic [DIV_W-1:0] div_cnt;
    logic             tick, fall;

    frame_state_t     state;
    logic [10:0]      frame;
    logic [3:0]       bit_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             ext, brk;
    logic [2:0]       skip;
    logic [NKEYS-1:0] kr;

    logic [7:0]       data;
    logic             frame_ok;
    key_entry_t       entry;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            div_cnt  <= '0;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            div_cnt  <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick)
                clk_prev <= clk_sync[1];
        end
    end

    assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign fall = tick && clk_prev && !clk_sync[1];

    // Frame is shifted in from the top: after 11 bits, bit0=start, [8:1]=data, 9=parity, 10=stop.
    assign data     = frame[8:1];
    assign frame_ok = !frame[0] && frame[10] && (^frame[9:1]);

    ps2_keymap u_keymap (
        .key   ({ext, data}),
        .entry (entry)
    );

    // NOTE: the key matrix is a flop vector, not a RAM, so it takes the reset like any register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            frame      <= '0;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            ext        <= 1'b0;
            brk        <= 1'b0;
            skip       <= '0;
            kr         <= '1;
            mod_out    <= '1;
            code_valid <= 1'b0;
            code_byte  <= '0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall && !dat_sync[1]) begin
                        frame   <= {dat_sync[1], 10'b0};
                        bit_cnt <= 4'd1;
                        to_cnt  <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        frame   <= {dat_sync[1], frame[10:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        to_cnt  <= '0;
                        if (bit_cnt == 4'd10)
                            state <= CHECK;
                    end else if (tick) begin
                        if (to_cnt == TO_W'(TIMEOUT_TICKS - 1)) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (!frame_ok) begin
                        frame_err <= 1'b1;
                    end else begin
                        code_byte  <= data;
                        code_valid <= 1'b1;
                        if (skip != 3'd0) begin
                            skip <= skip - 3'd1;
                        end else if (data == CODE_E0) begin
                            ext <= 1'b1;
                        end else if (data == CODE_F0) begin
                            brk <= 1'b1;
                        end else if (data == CODE_E1) begin
                            skip <= 3'(PAUSE_SKIP);
                        end else if (is_reset_code(data)) begin
                            kr      <= '1;
                            mod_out <= '1;
                            ext     <= 1'b0;
                            brk     <= 1'b0;
                        end else begin
                            // Out-of-range indices fall through both loops untouched.
                            if (entry.hit && entry.is_mod) begin
                                for (int i = 0; i < MODS; i++)
                                    if (int'(entry.idx) == i) mod_out[i] <= brk;
                            end else if (entry.hit) begin
                                for (int i = 0; i < NKEYS; i++)
                                    if (int'(entry.idx) == i) kr[i] <= brk;
                            end
                            ext <= 1'b0;
                            brk <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: col_out gets its default first, so no path through the loops can infer a latch.
    always_comb begin
        col_out = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!row_sel[r])
                    col_out[c] = col_out[c] & kr[r*COLS + c];
    end

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Self-checking bench for ps2_key_matrix: bit-banged PS/2 frames, a code-byte scoreboard,
// and matrix/modifier reads against hand-derived Micro-80 layout values.
module tb_ps2_key_matrix;

    localparam int SAMPLE_DIV    = 4;
    localparam int TIMEOUT_TICKS = 40;
    localparam int ROWS          = 8;
    localparam int COLS          = 7;
    localparam int MODS          = 3;
    localparam int HALF_TICKS    = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            ps2_clk;
    logic            ps2_dat;
    logic [ROWS-1:0] row_sel;
    logic [COLS-1:0] col_out;
    logic [MODS-1:0] mod_out;
    logic            code_valid;
    logic [7:0]      code_byte;
    logic            frame_err;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         valid_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] sb_exp;

    always #5 clk = ~clk;

    ps2_key_matrix #(
        .SAMPLE_DIV    (SAMPLE_DIV),
        .TIMEOUT_TICKS (TIMEOUT_TICKS),
        .ROWS          (ROWS),
        .COLS          (COLS),
        .MODS          (MODS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .row_sel    (row_sel),
        .col_out    (col_out),
        .mod_out    (mod_out),
        .code_valid (code_valid),
        .code_byte  (code_byte),
        .frame_err  (frame_err)
    );

    // Scoreboard: every good frame pushes its byte; each code_valid pulse pops one.
    always @(negedge clk) begin
        if (code_valid) begin
            valid_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: code_byte=%h arrived with nothing expected", code_byte);
            end else begin
                sb_exp = exp_q.pop_front();
                if (code_byte !== sb_exp) begin
                    n_bad++;
                    $display("FAIL sb_code_byte: got %h want %h", code_byte, sb_exp);
                end
            end
        end
        if (frame_err)
            err_cnt++;
    end

    task automatic wait_ticks(input int n);
        repeat (n * SAMPLE_DIV) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        wait_ticks(HALF_TICKS);
        ps2_clk = 1'b0;
        wait_ticks(HALF_TICKS);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_parity);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ flip_parity, b, 1'b0};
        if (!flip_parity)
            exp_q.push_back(b);
        for (int i = 0; i < 11; i++)
            ps2_bit(f[i]);
        ps2_dat = 1'b1;
        wait_ticks(2 * HALF_TICKS);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [10:0] f;
        f = {1'b1, ~^b, b, 1'b0};
        for (int i = 0; i < nbits; i++)
            ps2_bit(f[i]);
        ps2_dat = 1'b1;
    endtask

    task automatic read_cols(input logic [ROWS-1:0] sel, output logic [COLS-1:0] c);
        row_sel = sel;
        #1;
        c = col_out;
    endtask

    task automatic test_reset();
        logic [COLS-1:0] c;
        rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; row_sel = '1;
        repeat (4) @(negedge clk);
        n_cmp++; if (code_valid !== 1'b0) begin n_bad++; $display("FAIL reset_code_valid: got %b want 0", code_valid); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_cmp++; if (code_byte !== 8'h00) begin n_bad++; $display("FAIL reset_code_byte: got %h want 00", code_byte); end
        n_cmp++; if (mod_out !== 3'b111) begin n_bad++; $display("FAIL reset_mod_out: got %b want 111", mod_out); end
        read_cols(8'h00, c);
        n_cmp++; if (c !== 7'h7F) begin n_bad++; $display("FAIL reset_matrix: got %h want 7f", c); end
        @(negedge clk);
        rst = 1'b0;
        wait_ticks(4);
    endtask

    task automatic test_make();
        logic [COLS-1:0] c;
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        send(8'h1C);
        n_cmp++; if (valid_cnt - v0 !== 1) begin n_bad++; $display("FAIL make_valid_count: got %0d want 1", valid_cnt - v0); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL make_err_count: got %0d want 0", err_cnt - e0); end
        read_cols(8'hFD, c);
        n_cmp++; if (c !== 7'h77) begin n_bad++; $display("FAIL make_row1: got %h want 77", c); end
        for (int r = 0; r < ROWS; r++) begin
            if (r != 1) begin
                read_cols(~(8'h01 << r), c);
                n_cmp++; if (c !== 7'h7F) begin n_bad++; $display("FAIL make_row%0d: got %h want 7f", r, c); end
            end
        end
    endtask

    task automatic test_break();
        logic [COLS-1:0] c;
        send(8'hF0); send(8'h1C);
        read_cols(8'hFD, c);
        n_cmp++; if (c !== 7'h7F) begin n_bad++; $display("FAIL break_row1: got %h want 7f", c); end
        // A plain 75 afterwards must be a keypad-8 make: brk and ext both cleared.
        send(8'h75);
        read_cols(8'hFD, c);
        n_cmp++; if (c !== 7'h7D) begin n_bad++; $display("FAIL break_flags_row1: got %h want 7d", c); end
        read_cols(8'h7F, c);
        n_cmp++; if (c !== 7'h7F) begin n_bad++; $display("FAIL break_flags_row7: got %h want 7f", c); end
        send(8'hF0); send(8'h75);
    endtask

    task automatic test_ext();
        logic [COLS-1:0] c;
        send(8'hE0); send(8'h75);
        read_cols(8'h7F, c);
        n_cmp++; if (c !== 7'h7B) begin n_bad++; $display("FAIL ext_up_row7: got %h want 7b", c); end
        read_cols(8'hFD, c);
        n_cmp++; if (c !== 7'h7F) begin n_bad++; $display("FAIL ext_up_row1: got %h want 7f", c); end
        send(8'hE0); send(8'hF0); send(8'h75);
        read_cols(8'h7F, c);
        n_cmp++; if (c !== 7'h7F) begin n_bad++; $display("FAIL ext_up_release: got %h want 7f", c); end
        send(8'h75);
        read_cols(8'hFD, c);
        n_cmp++; if (c !== 7'h7D) begin n_bad++; $display("FAIL kp8_row1: got %h want 7d", c); end
        read_cols(8'h7F, c);
        n_cmp++; if (c !== 7'h7F) begin n_bad++; $display("FAIL kp8_row7: got %h want 7f", c); end
        send(8'hF0); send(8'h75);
    endtask

    task automatic test_parity();
        logic [COLS-1:0] c;
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h1C, 1'b1);
        n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL parity_err_count: got %0d want 1", err_cnt - e0); end
        n_cmp++; if (valid_cnt - v0 !== 0) begin n_bad++; $display("FAIL parity_valid_count: got %0d want 0", valid_cnt - v0); end
        read_cols(8'h00, c);
        n_cmp++; if (c !== 7'h7F) begin n_bad++; $display("FAIL parity_matrix: got %h want 7f", c); end
    endtask

    task automatic test_timeout();
        logic [COLS-1:0] c;
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        send_partial(8'h1C, 5);
        wait_ticks(TIMEOUT_TICKS + 10);
        n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL timeout_err_count: got %0d want 1", err_cnt - e0); end
        n_cmp++; if (valid_cnt - v0 !== 0) begin n_bad++; $display("FAIL timeout_valid_count: got %0d want 0", valid_cnt - v0); end
        send(8'h1C);
        n_cmp++; if (valid_cnt - v0 !== 1) begin n_bad++; $display("FAIL timeout_recover_count: got %0d want 1", valid_cnt - v0); end
        read_cols(8'hFD, c);
        n_cmp++; if (c !== 7'h77) begin n_bad++; $display("FAIL timeout_recover_row1: got %h want 77", c); end
        send(8'hF0); send(8'h1C);
    endtask

    task automatic test_bat();
        logic [COLS-1:0] c;
        send(8'h1C); send(8'h14); send(8'h12); send(8'h66);
        n_cmp++; if (mod_out !== 3'b010) begin n_bad++; $display("FAIL bat_mods_ctrl_bs: got %b want 010", mod_out); end
        read_cols(8'h7F, c);
        n_cmp++; if (c !== 7'h3F) begin n_bad++; $display("FAIL bat_shift_row7: got %h want 3f", c); end
        send(8'h07);
        n_cmp++; if (mod_out !== 3'b000) begin n_bad++; $display("FAIL bat_mods_all: got %b want 000", mod_out); end
        send(8'hAA);
        n_cmp++; if (mod_out !== 3'b111) begin n_bad++; $display("FAIL bat_mods_clear: got %b want 111", mod_out); end
        read_cols(8'h00, c);
        n_cmp++; if (c !== 7'h7F) begin n_bad++; $display("FAIL bat_matrix_clear: got %h want 7f", c); end
    endtask

    task automatic test_pause();
        logic [COLS-1:0] c;
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++)
            send(seq[i]);
        send(8'h1C);
        n_cmp++; if (mod_out !== 3'b111) begin n_bad++; $display("FAIL pause_mods: got %b want 111", mod_out); end
        read_cols(8'h00, c);
        n_cmp++; if (c !== 7'h77) begin n_bad++; $display("FAIL pause_all_rows: got %h want 77", c); end
        read_cols(8'hFD, c);
        n_cmp++; if (c !== 7'h77) begin n_bad++; $display("FAIL pause_row1: got %h want 77", c); end
        send(8'hF0); send(8'h1C);
    endtask

    task automatic test_back_to_back();
        logic [COLS-1:0] c;
        send(8'h1C); send(8'h32); send(8'h21); send(8'h24);
        read_cols(8'hFD, c);
        n_cmp++; if (c !== 7'h47) begin n_bad++; $display("FAIL b2b_row1: got %h want 47", c); end
        read_cols(8'hF9, c);
        n_cmp++; if (c !== 7'h46) begin n_bad++; $display("FAIL b2b_rows12: got %h want 46", c); end
        read_cols(8'hFF, c);
        n_cmp++; if (c !== 7'h7F) begin n_bad++; $display("FAIL b2b_no_rows: got %h want 7f", c); end
        send(8'hF0); send(8'h32);
        read_cols(8'hFD, c);
        n_cmp++; if (c !== 7'h57) begin n_bad++; $display("FAIL b2b_release_b: got %h want 57", c); end
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h21); send(8'hF0); send(8'h24);
        read_cols(8'h00, c);
        n_cmp++; if (c !== 7'h7F) begin n_bad++; $display("FAIL b2b_all_released: got %h want 7f", c); end
    endtask

    task automatic test_reset_mid_frame();
        logic [COLS-1:0] c;
        send(8'h1C);
        send_partial(8'h32, 5);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        read_cols(8'h00, c);
        n_cmp++; if (c !== 7'h7F) begin n_bad++; $display("FAIL midrst_matrix: got %h want 7f", c); end
        wait_ticks(4);
        send(8'h1C);
        read_cols(8'h00, c);
        n_cmp++; if (c !== 7'h77) begin n_bad++; $display("FAIL midrst_recover: got %h want 77", c); end
    endtask

    task automatic drain();
        int budget;
        budget = 1000;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d bytes still outstanding, want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_ext();
        test_parity();
        test_timeout();
        test_bat();
        test_pause();
        test_back_to_back();
        test_reset_mid_frame();
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_matrix.md
Name: ps2_key_matrix

Overview:
- Parametrised PS/2 keyboard receiver and scan-code-to-matrix converter for the retro-machine cores (Micro-80 and successors).
- Deframes PS/2 bytes with a synchronised, debounced input path and validates start, odd-parity and stop bits.
- Tracks E0/F0/E1 prefixes and holds a ROWS x COLS key matrix plus MODS modifier lines.
- The CPU-side PPI scans the matrix with active-low row selects, exactly as the hardware keyboard of the emulated machine would be scanned.

Parameters:
- SAMPLE_DIV, 250: clk cycles per PS/2 sample tick.
- TIMEOUT_TICKS, 4000: sample ticks without a falling edge before a partial frame is discarded.
- ROWS, 8: scan rows, driven by the PPI port A.
- COLS, 7: return columns, read on the PPI port B.
- MODS, 3: modifier lines, read on the PPI port C (bit0 RUS, bit1 US, bit2 SS in the Micro-80 map).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_dat  in  1  raw PS/2 data, asynchronous.
- row_sel  in  ROWS  active-low row select.
- col_out  out  COLS  active-low column return; combinational from row_sel and the matrix.
- mod_out  out  MODS  active-low modifier levels.
- code_valid  out  1  one-clk pulse when a good byte is received.
- code_byte  out  8  last good byte; held until the next good byte.
- frame_err  out  1  one-clk pulse on a parity/start/stop error or a timeout.

Behaviour:
- Reset (rst=1 at posedge clk), all synchronous:
  - Key matrix all 1s, mod_out all 1s.
  - code_valid=0, frame_err=0, code_byte=0.
  - Frame FSM in IDLE, prefix flags cleared, divider=0.
- Input path:
  - Each raw line passes through a 2-FF synchroniser.
  - The divider counts 0..SAMPLE_DIV-1 and asserts tick for one clk at SAMPLE_DIV-1.
  - On each tick the synchronised ps2_clk is sampled. A falling edge is prev=1, cur=0 between consecutive ticks.
- Frame FSM, advancing on ticks only:
  - IDLE: a falling edge with dat=0 loads the start bit, sets bitcnt=1 and moves to SHIFT. A falling edge with dat=1 is ignored.
  - SHIFT: each falling edge shifts dat in LSB-first and increments bitcnt. When bitcnt reaches 11, go to CHECK.
  - SHIFT timeout: the timeout counter resets on every edge. When it reaches TIMEOUT_TICKS, pulse frame_err and return to IDLE; the partial byte is discarded.
  - CHECK (one clk, no tick needed): the frame is good if start=0, stop=1 and XOR(data, parity)=1.
    - Good: code_byte<=data, pulse code_valid, run the decoder.
    - Bad: pulse frame_err only.
    - Either way, return to IDLE.
- Decoder, acting on good bytes in the CHECK cycle:
  - E0: set ext.
  - F0: set brk.
  - E1: set skip=7. The next 7 good bytes are consumed without action (Pause sequence).
  - AA, FC, 00, FF (BAT result / overrun): matrix and mods set to all 1s; ext and brk cleared.
  - Any other byte: look up (hit, is_mod, idx) in the keymap using {ext, byte}.
    - On hit, the target bit is written with brk: make writes 0, break writes 1.
    - ext and brk are cleared after any non-prefix byte, hit or miss.
  - An idx >= ROWS*COLS (or >= MODS for a modifier) is ignored.
  - A repeated make (typematic) rewrites 0: idempotent.
- Matrix output: col_out[c] = AND over r of (row_sel[r] OR kr[r*COLS+c]).
  - Several rows may be selected at once.
  - All rows deselected gives all 1s.
- Frames in flight: a frame error or timeout does not clear the prefix flags. A reset mid-frame discards the frame.

Decomposition:
- Package ps2_pkg:
  - Prefix byte constants E0, F0, E1.
  - BAT/overrun code constants.
  - Keymap entry typedef {hit, is_mod, idx[7:0]}.
  - Frame FSM state enum {IDLE, SHIFT, CHECK}.
- Sub-module ps2_keymap: combinational lookup from the 9-bit {ext, code} to a keymap entry. Its default table is the Micro-80 8x7 layout:
  - Letters, digits and numpad keys.
  - Arrows use the E0 codes.
  - Shift is bit 55.
  - Ctrl maps to SS, F12 to US, Backspace to RUS.

Test Plan:
1. rst, then send 1C (A make) -> code_valid pulse with code_byte=1C; row_sel=FD (row 1 low) gives col_out=77 (bit3 low); all other rows read 7F.
2. Send F0 1C -> after the second byte col_out=7F on row 1; ext and brk are clear.
3. Send E0 75 (Up) -> row 7 low gives col_out bit2=0; a plain 75 (numpad 8) instead gives row 1, bit1=0.
4. Send 1C with the parity bit flipped -> frame_err pulse, no code_valid, matrix unchanged.
5. Send 5 clock edges then idle for TIMEOUT_TICKS+10 ticks -> frame_err pulse; the next full 1C frame decodes correctly.
6. Press A, Ctrl and Shift, then send AA -> matrix and mod_out all 1s. Separately, send E1 followed by 7 bytes and then 1C -> only 1C takes effect.
